// File: rtl/stack_lifo.sv
// Parametrised LIFO stack with push/pop interface, registered dout/top peek,
// occupancy status and sticky overflow/underflow flags.
module stack_lifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic [WIDTH-1:0]  top,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   SP_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   SP_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   SP_TWO  = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W:0]   sp_reg, sp_next;
    logic [WIDTH-1:0]  dout_reg, dout_next;
    logic              dout_valid_reg, dout_valid_next;
    logic [WIDTH-1:0]  top_reg, top_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] idx_free, idx_top, idx_below;
    logic              is_empty, is_full;

    assign is_empty  = (sp_reg == '0);
    assign is_full   = (sp_reg == SP_FULL);
    assign idx_free  = sp_reg[ADDR_W-1:0];
    assign idx_top   = idx_free - IDX_ONE;
    assign idx_below = idx_free - IDX_TWO;

    always_comb begin
        sp_next         = sp_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        top_next        = top_reg;
        overflow_next   = overflow_reg & ~clr_err;
        underflow_next  = underflow_reg & ~clr_err;
        mem_we          = 1'b0;
        mem_waddr       = idx_free;

        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    mem_we   = 1'b1;
                    sp_next  = sp_reg + SP_ONE;
                    top_next = din;
                end else begin
                    overflow_next = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    dout_next       = mem[idx_top];
                    dout_valid_next = 1'b1;
                    sp_next         = sp_reg - SP_ONE;
                    top_next        = (sp_reg >= SP_TWO) ? mem[idx_below] : '0;
                end else begin
                    underflow_next = 1'b1;
                end
            end
            2'b11: begin
                dout_valid_next = 1'b1;
                if (!is_empty) begin
                    // Replace the top entry in place: old value out, new value in.
                    dout_next = mem[idx_top];
                    mem_we    = 1'b1;
                    mem_waddr = idx_top;
                    top_next  = din;
                end else begin
                    dout_next = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg         <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            top_reg        <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            sp_reg         <= sp_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            top_reg        <= top_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= din;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign top        = top_reg;
    assign count      = sp_reg;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_stack_lifo.sv
// Scenario bench for stack_lifo: a behavioural stack model queues expected
// popped words as stimulus is driven; each scenario compares them on output.
module tb_stack_lifo;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [WIDTH-1:0]  din = '0;
    logic [WIDTH-1:0]  dout, top;
    logic              dout_valid, empty, full, overflow, underflow;
    logic [ADDR_W:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] exp_q[$];

    stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .top(top),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Drive one operation for one edge, update the model, sample #1 after the edge.
    task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        push = p; pop = q; din = d; clr_err = c;
        if (p && q) begin
            if (model.size() > 0) begin
                exp_q.push_back(model[model.size()-1]);
                model[model.size()-1] = d;
            end else begin
                exp_q.push_back(d);
            end
        end else if (q) begin
            if (model.size() > 0) exp_q.push_back(model.pop_back());
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(d);
        end
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (model.size() > 0) ? model[model.size()-1] : '0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (count !== 0 || empty !== 1 || full !== 0 || dout !== 0 || dout_valid !== 0 ||
            top !== 0 || overflow !== 0 || underflow !== 0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d emp=%b ful=%b dout=%h dv=%b top=%h ov=%b un=%b",
                     count, empty, full, dout, dout_valid, top, overflow, underflow);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("reset: cnt=%0d empty=%b", count, empty);
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] vals [3] = '{8'h12, 8'h77, 8'h69};
        logic [WIDTH-1:0] tops [3] = '{8'h77, 8'h12, 8'h00};
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, vals[i], 1'b0);
            $display("push %h: cnt=%0d top=%h", vals[i], count, top);
        end
        n_cmp++;
        if (count !== 3 || top !== 8'h69) begin
            n_fail++; $display("FAIL push3: cnt=%0d top=%h want 3/69", count, top);
        end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, '0, 1'b0);
            exp = exp_q.pop_front();
            n_cmp++;
            if (dout_valid !== 1 || dout !== exp || dout !== vals[2-i] || top !== tops[i]) begin
                n_fail++;
                $display("FAIL pop_seq: dv=%b dout=%h top=%h want 1/%h/%h", dout_valid, dout, top, exp, tops[i]);
            end
            $display("pop: dout=%h dv=%b top=%h cnt=%0d", dout, dout_valid, top, count);
        end
        n_cmp++;
        if (empty !== 1 || count !== 0) begin
            n_fail++; $display("FAIL drained: empty=%b cnt=%0d want 1/0", empty, count);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, WIDTH'(i), 1'b0);
        n_cmp++;
        if (full !== 1 || count !== DEPTH || top !== 8'h1F) begin
            n_fail++; $display("FAIL fill: full=%b cnt=%0d top=%h want 1/32/1f", full, count, top);
        end
        op(1'b1, 1'b0, 8'hAA, 1'b0);
        $display("push aa when full: cnt=%0d ov=%b", count, overflow);
        n_cmp++;
        if (overflow !== 1 || count !== DEPTH || top !== 8'h1F) begin
            n_fail++; $display("FAIL overflow: ov=%b cnt=%0d top=%h want 1/32/1f", overflow, count, top);
        end
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 1'b1, '0, 1'b0);
            exp = exp_q.pop_front();
            n_cmp++;
            if (dout_valid !== 1 || dout !== exp || top !== model_top() || full !== 0) begin
                n_fail++;
                $display("FAIL drain_full: i=%0d dv=%b dout=%h top=%h want %h/%h", i, dout_valid, dout, top, exp, model_top());
            end
        end
        n_cmp++;
        if (overflow !== 1 || empty !== 1) begin
            n_fail++; $display("FAIL ov_sticky: ov=%b empty=%b want 1/1", overflow, empty);
        end
        op(1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (overflow !== 0) begin
            n_fail++; $display("FAIL ov_clear: ov=%b want 0", overflow);
        end
    endtask

    task automatic test_underflow();
        logic [WIDTH-1:0] held;
        held = dout;
        op(1'b0, 1'b1, 8'hEE, 1'b0);
        $display("pop empty: un=%b dv=%b dout=%h", underflow, dout_valid, dout);
        n_cmp++;
        if (underflow !== 1 || dout_valid !== 0 || dout !== held || count !== 0) begin
            n_fail++; $display("FAIL underflow: un=%b dv=%b dout=%h want 1/0/%h", underflow, dout_valid, dout, held);
        end
        op(1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (underflow !== 0) begin
            n_fail++; $display("FAIL un_clear: un=%b want 0", underflow);
        end
        op(1'b0, 1'b1, '0, 1'b1);
        n_cmp++;
        if (underflow !== 1) begin
            n_fail++; $display("FAIL un_set_wins: un=%b want 1", underflow);
        end
        op(1'b0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (underflow !== 0 || overflow !== 0) begin
            n_fail++; $display("FAIL flags_clear: un=%b ov=%b want 0/0", underflow, overflow);
        end
    endtask

    task automatic test_replace();
        logic [WIDTH-1:0] exp;
        op(1'b1, 1'b0, 8'h12, 1'b0);
        op(1'b1, 1'b0, 8'h77, 1'b0);
        op(1'b1, 1'b1, 8'h55, 1'b0);
        exp = exp_q.pop_front();
        $display("replace 55: dout=%h dv=%b cnt=%0d top=%h", dout, dout_valid, count, top);
        n_cmp++;
        if (dout !== exp || dout !== 8'h77 || dout_valid !== 1 || count !== 2 || top !== 8'h55 ||
            overflow !== 0 || underflow !== 0) begin
            n_fail++; $display("FAIL replace: dout=%h dv=%b cnt=%0d top=%h want 77/1/2/55", dout, dout_valid, count, top);
        end
        for (int i = 0; i < 2; i++) begin
            op(1'b0, 1'b1, '0, 1'b0);
            exp = exp_q.pop_front();
            n_cmp++;
            if (dout_valid !== 1 || dout !== exp || top !== model_top()) begin
                n_fail++; $display("FAIL replace_pop: dout=%h top=%h want %h/%h", dout, top, exp, model_top());
            end
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp;
        op(1'b1, 1'b1, 8'h3C, 1'b0);
        exp = exp_q.pop_front();
        $display("bypass 3c: dout=%h dv=%b cnt=%0d", dout, dout_valid, count);
        n_cmp++;
        if (dout !== exp || dout_valid !== 1 || count !== 0 || empty !== 1 || top !== 0 ||
            overflow !== 0 || underflow !== 0) begin
            n_fail++; $display("FAIL bypass: dout=%h dv=%b cnt=%0d emp=%b top=%h", dout, dout_valid, count, empty, top);
        end
        op(1'b0, 1'b0, '0, 1'b0);
        n_cmp++;
        if (dout_valid !== 0 || dout !== 8'h3C) begin
            n_fail++; $display("FAIL idle_after_bypass: dv=%b dout=%h want 0/3c", dout_valid, dout);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, WIDTH'(8'hA0 + i), 1'b0);
        op(1'b0, 1'b1, '0, 1'b0);
        void'(exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        model.delete();
        exp_q.delete();
        $display("async reset: cnt=%0d top=%h dout=%h dv=%b", count, top, dout, dout_valid);
        n_cmp++;
        if (count !== 0 || top !== 0 || dout !== 0 || dout_valid !== 0 || overflow !== 0 || underflow !== 0) begin
            n_fail++; $display("FAIL async_reset: cnt=%0d top=%h dout=%h dv=%b", count, top, dout, dout_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        op(1'b1, 1'b0, 8'h01, 1'b0);
        n_cmp++;
        if (count !== 1 || top !== 8'h01) begin
            n_fail++; $display("FAIL post_reset_push: cnt=%0d top=%h want 1/01", count, top);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_lifo.md
Name: stack_lifo

Overview:
- Parametrised hardware LIFO stack: successor to the fixed 8-bit/32-entry stack RAM.
- Replaces raw address/wren access with a push/pop interface. Tracks the stack pointer internally.
- Adds full/empty status, occupancy count, a registered top-of-stack peek, and sticky overflow/underflow error flags.
- Sits between CPU/test logic and the 7-segment display path; dout/top feed led_disp nibble decoders.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 32: number of entries; any value >= 2.
- ADDR_W, 5: pointer width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  push request, sampled on rising edge.
- pop  input  1  pop request, sampled on rising edge.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of overflow/underflow.
- dout  output  WIDTH  popped data, registered.
- dout_valid  output  1  one-cycle pulse: dout holds newly popped data.
- top  output  WIDTH  current top-of-stack value, registered; 0 when empty.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full without pop.
- underflow  output  1  sticky: pop attempted while empty without push.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sp = 0, so count = 0, empty = 1, full = 0.
  - dout = 0, dout_valid = 0, top = 0, overflow = 0, underflow = 0.
  - Storage array contents are not reset.
- Storage: register array of DEPTH x WIDTH. sp is the index of the next free slot; count = sp.
- Latency: all outputs are registered and reflect an operation on the cycle after its sampling edge. dout_valid is 0 on every cycle with no successful pop.
- Operation table (evaluated each rising edge):
  - Idle (push=0, pop=0): no change; dout holds its last value.
  - Push only, not full: mem[sp] <= din; sp <= sp+1; top <= din.
  - Push only, full: ignored; storage and sp unchanged; overflow <= 1.
  - Pop only, not empty: dout <= mem[sp-1]; dout_valid <= 1; sp <= sp-1; top <= mem[sp-2] if sp >= 2, else 0.
  - Pop only, empty: ignored; dout_valid <= 0; dout unchanged; underflow <= 1.
  - Push+pop, not empty (includes full): replace top. dout <= mem[sp-1]; dout_valid <= 1; mem[sp-1] <= din; top <= din; sp unchanged. No error flag set.
  - Push+pop, empty: bypass. dout <= din; dout_valid <= 1; sp stays 0; top stays 0. No error flag set.
- clr_err:
  - Clears overflow and underflow on the next edge.
  - If an error condition occurs on the same edge, set wins and the flag stays 1.
- Wrap-around: sp never wraps; it saturates at 0 and DEPTH through the ignore rules above.
- Reset mid-operation:
  - Asynchronous assertion immediately forces all reset values, including dropping dout_valid mid-pulse.
  - Deassertion takes effect at the next edge. An operation requested on the first edge after deassertion executes normally.
- count, empty and full are derived from the registered sp, so they update together with top.

Test Plan:
- Reset, then push 0x12, 0x77, 0x69 on consecutive cycles, then pop 3x -> count 3 after pushes, top=0x69. Pops yield dout 0x69, 0x77, 0x12 each with a dout_valid pulse. top goes 0x77, 0x12, 0; empty=1 at the end.
- Push DEPTH values 0..31 -> full=1, count=32. One extra push of 0xAA -> overflow=1, count stays 32. Next pop returns 0x1F, not 0xAA.
- From empty, pop -> underflow=1, dout_valid=0, dout unchanged. Then clr_err for one cycle -> underflow=0. Repeat with pop and clr_err on the same edge -> underflow=1.
- Stack holding 0x12, 0x77: push+pop with din=0x55 -> dout=0x77, dout_valid=1, count=2, top=0x55. Then pop 2x -> 0x55, 0x12.
- Empty stack: push+pop with din=0x3C -> dout=0x3C, dout_valid=1, count=0, empty=1, no error flags.
- Push 5 values, assert rst_n low asynchronously between edges -> count=0, top=0, dout=0, flags=0 immediately. After release, push 0x01 -> count=1, top=0x01.
